// File: rtl/dslot_nn_pkg.sv
// Shared definitions for the dslot neural-network datapath: default widths,
// accumulator FSM states and the minimum safe accumulator width.
package dslot_nn_pkg;

    localparam int SUM_W_DEFAULT  = 21;
    localparam int BIAS_W_DEFAULT = 16;
    localparam int OUT_W_DEFAULT  = 16;

    typedef enum logic [1:0] {
        ACC  = 2'd0,
        FIN  = 2'd1,
        HOLD = 2'd2
    } acc_state_t;

    // Smallest accumulator width that holds NUM_TILES sums plus a bias without wrapping.
    function automatic int acc_w_min(input int sum_w, input int num_tiles, input int bias_w);
        int grown;
        grown = sum_w + $clog2(num_tiles);
        return ((grown > bias_w) ? grown : bias_w) + 1;
    endfunction

endpackage

// File: rtl/relu_sat_requant.sv
// Combinational requantizer: adds bias, arithmetic right shift, ReLU and
// saturation to the largest positive OUT_W value, with a clip flag.
module relu_sat_requant #(
    parameter int ACC_W  = 24,
    parameter int BIAS_W = 16,
    parameter int SHIFT  = 4,
    parameter int OUT_W  = 16
) (
    input  logic signed [ACC_W-1:0]  acc,
    input  logic signed [BIAS_W-1:0] bias,
    output logic        [OUT_W-1:0]  data,
    output logic                     sat
);

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};

    logic signed [ACC_W-1:0] bias_ext;
    logic signed [ACC_W-1:0] pre;
    logic signed [ACC_W-1:0] shifted;

    assign bias_ext = {{(ACC_W-BIAS_W){bias[BIAS_W-1]}}, bias};
    assign pre      = acc + bias_ext;
    assign shifted  = pre >>> SHIFT;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        data = '0;
        sat  = 1'b0;
        if (shifted[ACC_W-1]) begin
            data = '0;
        end else if (shifted > SAT_MAX) begin
            data = SAT_MAX[OUT_W-1:0];
            sat  = 1'b1;
        end else begin
            data = shifted[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/neuron_accumulator.sv
// Accumulates NUM_TILES adder-tree sums per neuron, then requantizes through
// relu_sat_requant and holds the activation on a valid/ready output.
module neuron_accumulator
    import dslot_nn_pkg::*;
#(
    parameter int SUM_W     = SUM_W_DEFAULT,
    parameter int NUM_TILES = 4,
    parameter int BIAS_W    = BIAS_W_DEFAULT,
    parameter int ACC_W     = acc_w_min(SUM_W, NUM_TILES, BIAS_W),
    parameter int SHIFT     = 4,
    parameter int OUT_W     = OUT_W_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [SUM_W-1:0]  in_sum,
    input  logic signed [BIAS_W-1:0] bias,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic        [OUT_W-1:0]  out_data,
    output logic                     out_sat
);

    localparam int              CNT_W     = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
    localparam logic [CNT_W-1:0] LAST_TILE = CNT_W'(NUM_TILES - 1);

    acc_state_t              state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic        [CNT_W-1:0] tile_cnt_q, tile_cnt_d;
    logic signed [BIAS_W-1:0] bias_q, bias_d;
    logic                    out_valid_q, out_valid_d;
    logic        [OUT_W-1:0] out_data_q, out_data_d;
    logic                    out_sat_q, out_sat_d;

    logic signed [ACC_W-1:0] sum_ext;
    logic        [OUT_W-1:0] res_data;
    logic                    res_sat;

    assign sum_ext = {{(ACC_W-SUM_W){in_sum[SUM_W-1]}}, in_sum};

    relu_sat_requant #(
        .ACC_W (ACC_W),
        .BIAS_W(BIAS_W),
        .SHIFT (SHIFT),
        .OUT_W (OUT_W)
    ) u_requant (
        .acc (acc_q),
        .bias(bias_q),
        .data(res_data),
        .sat (res_sat)
    );

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        tile_cnt_d  = tile_cnt_q;
        bias_d      = bias_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        case (state_q)
            ACC: begin
                if (in_valid) begin
                    // First tile of a neuron restarts the sum and captures its bias.
                    if (tile_cnt_q == '0) begin
                        acc_d  = sum_ext;
                        bias_d = bias;
                    end else begin
                        acc_d = acc_q + sum_ext;
                    end
                    if (tile_cnt_q == LAST_TILE) begin
                        tile_cnt_d = '0;
                        state_d    = FIN;
                    end else begin
                        tile_cnt_d = tile_cnt_q + CNT_W'(1);
                    end
                end
            end
            FIN: begin
                out_data_d  = res_data;
                out_sat_d   = res_sat;
                out_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ACC;
                end
            end
            default: state_d = ACC;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ACC;
            acc_q       <= '0;
            tile_cnt_q  <= '0;
            bias_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            tile_cnt_q  <= tile_cnt_d;
            bias_q      <= bias_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign in_ready  = (state_q == ACC);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_neuron_accumulator.sv
// Directed and randomized checks of neuron_accumulator; two instances share
// stimulus, one with SHIFT=0 and one with SHIFT=4.
module tb_neuron_accumulator;

    localparam int SUM_W     = 21;
    localparam int BIAS_W    = 16;
    localparam int OUT_W     = 16;
    localparam int NUM_TILES = 4;

    logic                     clk;
    logic                     rst;
    logic                     in_valid;
    logic                     out_ready;
    logic signed [SUM_W-1:0]  in_sum;
    logic signed [BIAS_W-1:0] bias;
    logic                     in_ready0, in_ready4;
    logic                     out_valid0, out_valid4;
    logic                     out_sat0, out_sat4;
    logic        [OUT_W-1:0]  out_data0, out_data4;

    int n_checks = 0;
    int n_fail   = 0;

    neuron_accumulator #(
        .SUM_W(SUM_W), .NUM_TILES(NUM_TILES), .BIAS_W(BIAS_W),
        .ACC_W(24), .SHIFT(0), .OUT_W(OUT_W)
    ) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .in_sum(in_sum), .bias(bias), .out_valid(out_valid0),
        .out_ready(out_ready), .out_data(out_data0), .out_sat(out_sat0)
    );

    neuron_accumulator #(
        .SUM_W(SUM_W), .NUM_TILES(NUM_TILES), .BIAS_W(BIAS_W),
        .ACC_W(24), .SHIFT(4), .OUT_W(OUT_W)
    ) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
        .in_sum(in_sum), .bias(bias), .out_valid(out_valid4),
        .out_ready(out_ready), .out_data(out_data4), .out_sat(out_sat4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: {sat, data} for a neuron sum, bias and shift.
    function automatic logic [16:0] model(input longint acc, input longint b, input int sh);
        longint t;
        t = (acc + b) >>> sh;
        if (t < 0) return 17'd0;
        if (t > 32767) return {1'b1, 16'd32767};
        return {1'b0, 16'(t)};
    endfunction

    task automatic send_tile(input int s, input int b);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_sum   = SUM_W'(s);
        bias     = BIAS_W'(b);
        while (!in_ready0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready0) begin
            n_fail++;
            $display("FAIL send_tile_timeout: in_ready=%0b required 1", in_ready0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!out_valid0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!out_valid0) begin
            n_fail++;
            $display("FAIL wait_valid_timeout: out_valid=%0b required 1", out_valid0);
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_sum = '0; bias = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        n_checks++;
        if ({in_ready0, out_valid0, out_sat0, out_data0} !== {1'b1, 1'b0, 1'b0, 16'd0}) begin
            n_fail++;
            $display("FAIL reset_s0: rdy=%0b v=%0b s=%0b d=%0d required 1 0 0 0", in_ready0, out_valid0, out_sat0, out_data0);
        end
        n_checks++;
        if ({in_ready4, out_valid4, out_sat4, out_data4} !== {1'b1, 1'b0, 1'b0, 16'd0}) begin
            n_fail++;
            $display("FAIL reset_s4: rdy=%0b v=%0b s=%0b d=%0d required 1 0 0 0", in_ready4, out_valid4, out_sat4, out_data4);
        end
    endtask

    task automatic test_reset_mid();
        send_tile(5000, 7);
        send_tile(5000, 7);
        rst = 1'b1;
        #2 rst = 1'b0;
        n_checks++;
        if ({in_ready0, out_valid0} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_mid_state: rdy=%0b v=%0b required 1 0", in_ready0, out_valid0);
        end
        for (int k = 0; k < 4; k++) send_tile(100, 0);
        wait_valid();
        n_checks++;
        if ({out_sat0, out_data0} !== {1'b0, 16'd400}) begin
            n_fail++;
            $display("FAIL reset_mid_s0: s=%0b d=%0d required 0 400", out_sat0, out_data0);
        end
        n_checks++;
        if ({out_sat4, out_data4} !== {1'b0, 16'd25}) begin
            n_fail++;
            $display("FAIL reset_mid_s4: s=%0b d=%0d required 0 25", out_sat4, out_data4);
        end
        consume();
    endtask

    task automatic test_shift_timing();
        send_tile(1000, -36);
        send_tile(2000, -36);
        send_tile(-500, -36);
        send_tile(36, -36);
        n_checks++;
        if ({in_ready0, out_valid0, in_ready4, out_valid4} !== 4'b0000) begin
            n_fail++;
            $display("FAIL fin_cycle: rdy0=%0b v0=%0b rdy4=%0b v4=%0b required 0 0 0 0", in_ready0, out_valid0, in_ready4, out_valid4);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({out_valid0, out_sat0, out_data0} !== {1'b1, 1'b0, 16'd2500}) begin
            n_fail++;
            $display("FAIL shift_s0: v=%0b s=%0b d=%0d required 1 0 2500", out_valid0, out_sat0, out_data0);
        end
        n_checks++;
        if ({out_valid4, out_sat4, out_data4} !== {1'b1, 1'b0, 16'd156}) begin
            n_fail++;
            $display("FAIL shift_s4: v=%0b s=%0b d=%0d required 1 0 156", out_valid4, out_sat4, out_data4);
        end
        consume();
    endtask

    task automatic test_relu();
        for (int k = 0; k < 4; k++) send_tile(-1048576, 0);
        wait_valid();
        n_checks++;
        if ({out_sat0, out_data0} !== {1'b0, 16'd0}) begin
            n_fail++;
            $display("FAIL relu_s0: s=%0b d=%0d required 0 0", out_sat0, out_data0);
        end
        n_checks++;
        if ({out_sat4, out_data4} !== {1'b0, 16'd0}) begin
            n_fail++;
            $display("FAIL relu_s4: s=%0b d=%0d required 0 0", out_sat4, out_data4);
        end
        consume();
    endtask

    task automatic test_saturate();
        for (int k = 0; k < 4; k++) send_tile(1048575, 32767);
        wait_valid();
        n_checks++;
        if ({out_sat0, out_data0} !== {1'b1, 16'd32767}) begin
            n_fail++;
            $display("FAIL sat_s0: s=%0b d=%0d required 1 32767", out_sat0, out_data0);
        end
        n_checks++;
        if ({out_sat4, out_data4} !== {1'b1, 16'd32767}) begin
            n_fail++;
            $display("FAIL sat_s4: s=%0b d=%0d required 1 32767", out_sat4, out_data4);
        end
        consume();
    endtask

    task automatic test_back_pressure();
        send_tile(10, 0);
        send_tile(20, 0);
        send_tile(30, 0);
        send_tile(40, 0);
        in_valid = 1'b1; in_sum = 21'sd1; bias = 16'sd5;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({in_ready0, out_valid0, out_sat0, out_data0} !== {1'b0, 1'b1, 1'b0, 16'd100}) begin
                n_fail++;
                $display("FAIL hold_s0[%0d]: rdy=%0b v=%0b s=%0b d=%0d required 0 1 0 100", i, in_ready0, out_valid0, out_sat0, out_data0);
            end
            n_checks++;
            if ({in_ready4, out_valid4, out_sat4, out_data4} !== {1'b0, 1'b1, 1'b0, 16'd6}) begin
                n_fail++;
                $display("FAIL hold_s4[%0d]: rdy=%0b v=%0b s=%0b d=%0d required 0 1 0 6", i, in_ready4, out_valid4, out_sat4, out_data4);
            end
            @(posedge clk); #1;
        end
        consume();
        n_checks++;
        if ({in_ready0, out_valid0, out_data0} !== {1'b1, 1'b0, 16'd100}) begin
            n_fail++;
            $display("FAIL after_handshake: rdy=%0b v=%0b d=%0d required 1 0 100", in_ready0, out_valid0, out_data0);
        end
        @(posedge clk); #1;
        send_tile(2, 999);
        send_tile(3, -999);
        send_tile(4, 77);
        wait_valid();
        n_checks++;
        if ({out_sat0, out_data0} !== {1'b0, 16'd15}) begin
            n_fail++;
            $display("FAIL next_neuron_s0: s=%0b d=%0d required 0 15", out_sat0, out_data0);
        end
        n_checks++;
        if ({out_sat4, out_data4} !== {1'b0, 16'd0}) begin
            n_fail++;
            $display("FAIL next_neuron_s4: s=%0b d=%0d required 0 0", out_sat4, out_data4);
        end
        consume();
    endtask

    task automatic test_random();
        logic [16:0] exp0[$];
        logic [16:0] exp4[$];
        int got;
        got = 0;
        fork
            begin
                for (int n = 0; n < 200; n++) begin
                    longint acc;
                    int b, s;
                    logic signed [15:0] rb;
                    logic signed [20:0] rs;
                    acc = 0;
                    rb = 16'($urandom);
                    b = rb;
                    for (int k = 0; k < NUM_TILES; k++) begin
                        if (n % 2 == 0) begin
                            s = int'($urandom_range(0, 4000)) - 2000;
                        end else begin
                            rs = 21'($urandom);
                            s = rs;
                        end
                        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                        send_tile(s, (k == 0) ? b : int'($urandom_range(0, 65535)) - 32768);
                        acc += s;
                    end
                    exp0.push_back(model(acc, b, 0));
                    exp4.push_back(model(acc, b, 4));
                end
            end
            begin
                int cyc;
                logic rdy;
                logic [16:0] e0, e4;
                cyc = 0;
                while (got < 200 && cyc < 20000) begin
                    rdy = ($urandom_range(0, 3) != 0);
                    out_ready = rdy;
                    if (out_valid0 && rdy) begin
                        if (exp0.size() == 0) begin
                            n_checks++;
                            n_fail++;
                            $display("FAIL rand_extra: unexpected output d=%0d", out_data0);
                        end else begin
                            e0 = exp0.pop_front();
                            e4 = exp4.pop_front();
                            n_checks++;
                            if ({out_valid4, out_sat0, out_data0} !== {1'b1, e0}) begin
                                n_fail++;
                                $display("FAIL rand_s0[%0d]: s=%0b d=%0d required %0b %0d", got, out_sat0, out_data0, e0[16], e0[15:0]);
                            end
                            n_checks++;
                            if ({out_sat4, out_data4} !== e4) begin
                                n_fail++;
                                $display("FAIL rand_s4[%0d]: s=%0b d=%0d required %0b %0d", got, out_sat4, out_data4, e4[16], e4[15:0]);
                            end
                        end
                        got++;
                    end
                    @(posedge clk); #1;
                    cyc++;
                end
                out_ready = 1'b0;
            end
        join
        n_checks++;
        if (got != 200 || exp0.size() != 0) begin
            n_fail++;
            $display("FAIL rand_count: outputs=%0d pending=%0d required 200 0", got, exp0.size());
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_shift_timing();
        test_relu();
        test_saturate();
        test_back_pressure();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
